// File: rtl/blake_pkg.sv
// Shared widths and controller state encoding for the blake nonce scanner.
package blake_pkg;

    localparam int unsigned HDR_W     = 640;
    localparam int unsigned DIG_W     = 512;
    localparam int unsigned NONCE_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/blake_nonce_scanner_if.sv
// din/ena request and rdy/dout response path between the scanner and one blake core.
interface blake_nonce_scanner_if;
    import blake_pkg::*;

    logic [HDR_W-1:0] core_din;
    logic             core_ena;
    logic             core_rdy;
    logic [DIG_W-1:0] core_dout;

    modport master (
        output core_din,
        output core_ena,
        input  core_rdy,
        input  core_dout
    );

    modport slave (
        input  core_din,
        input  core_ena,
        output core_rdy,
        output core_dout
    );

endinterface

// File: rtl/blake_cmp512.sv
// Unsigned digest-versus-target less-than comparator, purely combinational.
module blake_cmp512
    import blake_pkg::*;
(
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    output logic             lt
);

    always_comb begin
        lt = (a < b);
    end

endmodule

// File: rtl/blake_nonce_scanner.sv
// Nonce scan controller: issues one hash per nonce to a blake core and stops on
// the first digest below target, end of range, abort or core timeout.
module blake_nonce_scanner
    import blake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned NONCE_W     = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    input  logic                  abort,
    input  logic [HDR_W-1:0]      header_base,
    input  logic [31:0]           nonce_start,
    input  logic [31:0]           nonce_end,
    input  logic [DIG_W-1:0]      target,
    blake_nonce_scanner_if.master core,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  timeout,
    output logic [31:0]           found_nonce,
    output logic [DIG_W-1:0]      found_hash,
    output logic [31:0]           hash_count,
    output logic [15:0]           last_latency
);

    state_t           state;
    state_t           state_nxt;
    logic [HDR_W-1:0] hdr_q;
    logic [DIG_W-1:0] tgt_q;
    logic [DIG_W-1:0] hash_q;
    logic [31:0]      nonce_cur;
    logic [31:0]      nonce_end_q;
    logic [31:0]      lat_cnt;
    logic             rdy_q;
    logic             rdy_rise;
    logic             hash_lt;
    logic             last_nonce;
    logic             timed_out;
    logic [HDR_W-1:0] issue_din;

    blake_cmp512 u_cmp (
        .a  (hash_q),
        .b  (tgt_q),
        .lt (hash_lt)
    );

    // rdy is a level; rdy_q tracks it in every state so a stale high level never reads as completion
    assign rdy_rise   = core.core_rdy & ~rdy_q;
    assign last_nonce = (nonce_cur == nonce_end_q);
    // lat_cnt lags the ena cycle by one, so DONE lands exactly TIMEOUT_CYC cycles after ena
    assign timed_out  = ((lat_cnt + 32'd2) >= TIMEOUT_CYC);

    always_comb begin
        issue_din = hdr_q;
        issue_din[NONCE_LSB +: NONCE_W] = nonce_cur[NONCE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = ISSUE;
                ISSUE:      state_nxt = WAIT;
                WAIT: begin
                    if (rdy_rise) begin
                        state_nxt = CHECK;
                    end else if (timed_out) begin
                        state_nxt = DONE;
                    end
                end
                CHECK:      state_nxt = (hash_lt || last_nonce) ? DONE : ISSUE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        core.core_ena = 1'b0;
        core.core_din = '0;
        case (state)
            ISSUE: begin
                busy          = 1'b1;
                core.core_ena = 1'b1;
                core.core_din = issue_din;
            end
            WAIT, CHECK: busy = 1'b1;
            DONE:        done = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            hdr_q        <= '0;
            tgt_q        <= '0;
            hash_q       <= '0;
            nonce_cur    <= '0;
            nonce_end_q  <= '0;
            lat_cnt      <= '0;
            rdy_q        <= 1'b0;
            found        <= 1'b0;
            timeout      <= 1'b0;
            found_nonce  <= '0;
            found_hash   <= '0;
            hash_count   <= '0;
            last_latency <= '0;
        end else begin
            rdy_q <= core.core_rdy;
            if (!abort) begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            hdr_q       <= header_base;
                            tgt_q       <= target;
                            nonce_cur   <= nonce_start;
                            nonce_end_q <= nonce_end;
                            hash_count  <= '0;
                            found       <= 1'b0;
                            timeout     <= 1'b0;
                        end
                    end
                    ISSUE: lat_cnt <= '0;
                    WAIT: begin
                        lat_cnt <= lat_cnt + 32'd1;
                        if (rdy_rise) begin
                            hash_q       <= core.core_dout;
                            last_latency <= (lat_cnt > 32'h0000_FFFF) ? 16'hFFFF : lat_cnt[15:0];
                            if (hash_count != '1) begin
                                hash_count <= hash_count + 32'd1;
                            end
                        end else if (timed_out) begin
                            timeout <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (hash_lt) begin
                            found       <= 1'b1;
                            found_nonce <= nonce_cur;
                            found_hash  <= hash_q;
                        end else if (!last_nonce) begin
                            nonce_cur <= nonce_cur + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blake_nonce_scanner.sv
// Self-checking bench for blake_nonce_scanner with a behavioural blake core stand-in
// and a job-level scan model.
module tb_blake_nonce_scanner;
    import blake_pkg::*;

    localparam int unsigned TMO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstb;
    logic             start;
    logic             abort;
    logic [HDR_W-1:0] header_base;
    logic [31:0]      nonce_start;
    logic [31:0]      nonce_end;
    logic [DIG_W-1:0] target;
    logic             busy;
    logic             done;
    logic             found;
    logic             timeout;
    logic [31:0]      found_nonce;
    logic [DIG_W-1:0] found_hash;
    logic [31:0]      hash_count;
    logic [15:0]      last_latency;

    blake_nonce_scanner_if bus ();

    blake_nonce_scanner #(.TIMEOUT_CYC(TMO), .NONCE_W(32)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .abort        (abort),
        .header_base  (header_base),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .core         (bus.master),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .timeout      (timeout),
        .found_nonce  (found_nonce),
        .found_hash   (found_hash),
        .hash_count   (hash_count),
        .last_latency (last_latency)
    );

    // Stand-in digest: any deterministic mix of the nonce and header words will do.
    function automatic logic [DIG_W-1:0] digest(input logic [HDR_W-1:0] din);
        logic [DIG_W-1:0] d;
        logic [31:0]      n;
        n = din[31:0];
        for (int i = 0; i < 16; i++) begin
            d[32*i +: 32] = ((n ^ 32'(i)) * 32'h9E37_79B1) ^ din[128 + 32*i +: 32];
        end
        return d;
    endfunction

    // Core stand-in: rdy rises core_lat clocks after the edge that samples ena and
    // stays high until the next ena; core_lat == 0 never answers.
    int unsigned      core_lat = 1;
    bit               man_mode = 1'b0;
    logic             man_rdy  = 1'b0;
    logic             rdy_m    = 1'b0;
    logic [DIG_W-1:0] dout_m   = '0;
    logic [HDR_W-1:0] din_hold = '0;
    bit               pend     = 1'b0;
    int unsigned      pcnt     = 0;

    assign bus.core_rdy  = man_mode ? man_rdy : rdy_m;
    assign bus.core_dout = dout_m;

    always @(posedge clk) begin
        if (bus.core_ena) begin
            din_hold <= bus.core_din;
            pend     <= 1'b1;
            pcnt     <= 0;
            rdy_m    <= 1'b0;
        end else if (pend && core_lat != 0) begin
            if (pcnt + 1 == core_lat) begin
                rdy_m  <= 1'b1;
                dout_m <= digest(din_hold);
                pend   <= 1'b0;
            end else begin
                pcnt <= pcnt + 1;
            end
        end
    end

    int unsigned      cyc = 0;
    logic [31:0]      seen_q[$];
    int unsigned      ena_stamp[$];
    int unsigned      din_leak = 0;
    int unsigned      hdr_bad  = 0;
    logic [HDR_W-1:0] exp_hdr  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.core_ena) begin
            seen_q.push_back(bus.core_din[31:0]);
            ena_stamp.push_back(cyc);
            if (bus.core_din[HDR_W-1:32] != exp_hdr[HDR_W-1:32]) hdr_bad++;
        end else if (bus.core_din != '0) begin
            din_leak++;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [HDR_W-1:0] got, input logic [HDR_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Job-level reference: walk the inclusive range with 32-bit wrap, stop on first digest < target.
    logic [31:0] exp_nonces[$];

    task automatic model_job(input logic [HDR_W-1:0] hdr, input logic [31:0] ns, input logic [31:0] ne,
                             input logic [DIG_W-1:0] tgt, output bit f, output logic [31:0] fn,
                             output logic [DIG_W-1:0] fh, output int unsigned cnt);
        logic [31:0]      n;
        logic [HDR_W-1:0] h;
        logic [DIG_W-1:0] d;
        exp_nonces.delete();
        f   = 1'b0;
        fn  = '0;
        fh  = '0;
        cnt = 0;
        n   = ns;
        for (int k = 0; k < 64; k++) begin
            h = hdr;
            h[31:0] = n;
            d = digest(h);
            cnt++;
            exp_nonces.push_back(n);
            if (d < tgt) begin
                f  = 1'b1;
                fn = n;
                fh = d;
                break;
            end
            if (n == ne) break;
            n = n + 32'd1;
        end
    endtask

    task automatic start_job(input logic [HDR_W-1:0] hdr, input logic [31:0] ns, input logic [31:0] ne,
                             input logic [DIG_W-1:0] tgt);
        @(negedge clk);
        header_base = hdr;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        exp_hdr     = hdr;
        seen_q.delete();
        ena_stamp.delete();
        din_leak    = 0;
        hdr_bad     = 0;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        // job parameters must have been latched; scramble the live inputs
        header_base = {20{$urandom}};
        nonce_start = $urandom;
        nonce_end   = $urandom;
        target      = {16{$urandom}};
    endtask

    task automatic wait_done(input string nm, input int unsigned budget, output int unsigned dc);
        for (int unsigned k = 0; k < budget && !done; k++) @(negedge clk);
        dc = cyc;
        check($sformatf("%s.done", nm), done, 1);
    endtask

    task automatic run_and_check(input string nm, input logic [HDR_W-1:0] hdr, input logic [31:0] ns,
                                 input logic [31:0] ne, input logic [DIG_W-1:0] tgt,
                                 input int unsigned lat);
        bit               f;
        logic [31:0]      fn;
        logic [DIG_W-1:0] fh;
        int unsigned      cnt, dc, nseen;
        core_lat = lat;
        model_job(hdr, ns, ne, tgt, f, fn, fh, cnt);
        start_job(hdr, ns, ne, tgt);
        wait_done(nm, cnt * (lat + 3) + 40, dc);
        check($sformatf("%s.found", nm), found, f);
        if (f) begin
            check($sformatf("%s.nonce", nm), found_nonce, fn);
            check($sformatf("%s.hash", nm), found_hash, fh);
        end
        check($sformatf("%s.count", nm), hash_count, cnt);
        check($sformatf("%s.timeout", nm), timeout, 0);
        check($sformatf("%s.latency", nm), last_latency, lat);
        check($sformatf("%s.issued", nm), seen_q.size(), cnt);
        nseen = (seen_q.size() < cnt) ? seen_q.size() : cnt;
        for (int i = 0; i < int'(nseen); i++) begin
            check($sformatf("%s.din_nonce%0d", nm, i), seen_q[i], exp_nonces[i]);
        end
        for (int i = 1; i < ena_stamp.size(); i++) begin
            check($sformatf("%s.ena_gap%0d", nm, i), ena_stamp[i] - ena_stamp[i-1], lat + 3);
        end
        check($sformatf("%s.din_idle", nm), din_leak, 0);
        check($sformatf("%s.din_hdr", nm), hdr_bad, 0);
    endtask

    task automatic check_zero(input string nm);
        check($sformatf("%s.ctl", nm),
              {busy, done, found, timeout, bus.core_ena, found_nonce, hash_count, last_latency}, '0);
        check($sformatf("%s.hash", nm), found_hash, '0);
        check($sformatf("%s.din", nm), bus.core_din, '0);
    endtask

    logic [HDR_W-1:0] hdr_v;
    logic [HDR_W-1:0] h_tmp;
    logic [DIG_W-1:0] dig_kv;
    logic [DIG_W-1:0] tgt_v;
    logic [31:0]      ns_v;
    logic [31:0]      ne_v;
    logic [31:0]      wrap_exp[4];
    int unsigned      dc;

    initial begin
        rstb        = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        header_base = '0;
        nonce_start = '0;
        nonce_end   = '0;
        target      = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rstb = 1'b0;

        // fixed header, single nonce, target one above its digest
        for (int i = 0; i < 20; i++) hdr_v[32*i +: 32] = 32'h6A09_E667 + 32'(i) * 32'h0100_0193;
        h_tmp = hdr_v;
        h_tmp[31:0] = 32'h0009_E22E;
        dig_kv = digest(h_tmp);
        run_and_check("kv_hit", hdr_v, 32'h0009_E22E, 32'h0009_E22E, dig_kv + 1'b1, 7);
        check("kv_hit.found_abs", found, 1);
        check("kv_hit.hash_abs", found_hash, dig_kv);
        check("kv_hit.ena_cycles", ena_stamp.size(), 1);

        // equal digest is not a hit
        run_and_check("kv_eq", hdr_v, 32'h0009_E22E, 32'h0009_E22E, dig_kv, 7);
        check("kv_eq.found_abs", found, 0);

        // wrap through all-ones
        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        run_and_check("wrap", hdr_v, 32'hFFFF_FFFE, 32'h0000_0001, '0, 4);
        check("wrap.count_abs", hash_count, 4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
            check($sformatf("wrap.order%0d", i), seen_q[i], wrap_exp[i]);
        end

        // 50-cycle core: 53-cycle nonce pitch
        run_and_check("lat50", hdr_v, 32'h0000_0010, 32'h0000_0012, '0, 50);
        check("lat50.latency_abs", last_latency, 50);

        // core never answers
        core_lat = 0;
        start_job(hdr_v, 32'd5, 32'd5, '1);
        wait_done("tmo", TMO + 20, dc);
        check("tmo.timeout", timeout, 1);
        check("tmo.found", found, 0);
        check("tmo.count", hash_count, 0);
        check("tmo.ena_cnt", ena_stamp.size(), 1);
        if (ena_stamp.size() > 0) check("tmo.delay", dc - ena_stamp[0], TMO);

        // abort beats start in DONE
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_prio", {busy, done}, 2'b00);

        // abort mid-WAIT, then a stale rdy rising into the next job
        man_mode = 1'b1;
        man_rdy  = 1'b0;
        core_lat = 1;
        start_job(hdr_v, 32'd100, 32'd200, '0);
        repeat (3) @(negedge clk);
        check("abt.busy_wait", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt.idle", {busy, done, bus.core_ena}, 3'b000);
        start_job(hdr_v, 32'd100, 32'd200, '0);
        man_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("stale.busy", busy, 1);
        check("stale.count", hash_count, 0);
        man_rdy = 1'b0;
        @(negedge clk);
        man_rdy = 1'b1;
        @(negedge clk);
        check("fresh.count", hash_count, 1);
        rstb = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rstb     = 1'b0;
        man_mode = 1'b0;
        man_rdy  = 1'b0;

        for (int j = 0; j < 8; j++) begin
            for (int w = 0; w < 20; w++) hdr_v[32*w +: 32] = $urandom;
            for (int w = 0; w < 16; w++) tgt_v[32*w +: 32] = $urandom;
            ns_v = $urandom;
            if ($urandom_range(0, 2) == 0) ns_v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            ne_v = ns_v + 32'($urandom_range(0, 5));
            run_and_check($sformatf("rnd%0d", j), hdr_v, ns_v, ne_v, tgt_v, $urandom_range(1, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
